timer_555_multi: RTL

- Multi-channel 555 timer emulation; counts CLK cycles to produce pulse outputs for sound and video timing circuits.
- Each channel runs in monostable mode (optionally retriggerable) or astable mode (free-running oscillator).
- Pulse and period lengths are runtime inputs, not synthesis constants.
- Each channel has a 555-style active-low reset pin.

---
 rtl/timer_555_multi.sv | 121 ++++++++++++
 1 files changed

// File: rtl/timer_555_multi.sv
// Multi-channel 555 timer emulation: each channel is a monostable (optionally
// retriggerable) or astable pulse generator clocked from CLK.
module timer_555_multi #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 16,
  parameter bit RETRIG   = 1'b0
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [CHANNELS-1:0]       TRG_N,
  input  logic [CHANNELS-1:0]       RST_N,
  input  logic [CHANNELS-1:0]       ASTABLE,
  input  logic [CHANNELS*WIDTH-1:0] HIGH_CNT,
  input  logic [CHANNELS*WIDTH-1:0] LOW_CNT,
  output logic [CHANNELS-1:0]       OUT,
  output logic [CHANNELS-1:0]       DONE
);

  // state  | meaning
  // IDLE   | waiting for a trigger (mono) or about to start (astable)
  // HIGH   | output high, counting the latched high length
  // END    | one-cycle DONE pulse, also the first low cycle in astable
  // LOW    | remaining low cycles of an astable period
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HIGH = 2'd1;
  localparam logic [1:0] S_END  = 2'd2;
  localparam logic [1:0] S_LOW  = 2'd3;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] lat_q, lat_d;
    logic             astb_q, astb_d;
    logic             prev_q;
    logic             detect;
    logic [WIDTH-1:0] hi_n, lo_n, term;

    // A programmed length of zero behaves as one cycle.
    assign hi_n   = (HIGH_CNT[i*WIDTH +: WIDTH] == '0) ? WIDTH'(1) : HIGH_CNT[i*WIDTH +: WIDTH];
    assign lo_n   = (LOW_CNT[i*WIDTH +: WIDTH] == '0) ? WIDTH'(1) : LOW_CNT[i*WIDTH +: WIDTH];
    assign detect = prev_q & ~TRG_N[i];
    assign term   = lat_q - WIDTH'(1);

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lat_d   = lat_q;
      astb_d  = astb_q;
      if (!RST_N[i]) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (ASTABLE[i] || detect) begin
              state_d = S_HIGH;
              cnt_d   = '0;
              lat_d   = hi_n;
              astb_d  = ASTABLE[i];
            end
          end
          S_HIGH: begin
            if (RETRIG && !astb_q && detect) begin
              cnt_d = '0;
              lat_d = hi_n;
            end else if (cnt_q == term) begin
              state_d = S_END;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + WIDTH'(1);
            end
          end
          S_END: begin
            astb_d = ASTABLE[i];
            if (!ASTABLE[i]) begin
              state_d = S_IDLE;
            end else if (lo_n == WIDTH'(1)) begin
              state_d = S_HIGH;
              cnt_d   = '0;
              lat_d   = hi_n;
            end else begin
              // END already served as the first low cycle.
              state_d = S_LOW;
              cnt_d   = WIDTH'(1);
              lat_d   = lo_n;
            end
          end
          default: begin
            if (cnt_q == term) begin
              state_d = S_HIGH;
              cnt_d   = '0;
              lat_d   = hi_n;
            end else begin
              cnt_d = cnt_q + WIDTH'(1);
            end
          end
        endcase
      end
    end

    always_ff @(posedge CLK) begin
      if (RESET) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
        lat_q   <= '0;
        astb_q  <= 1'b0;
        prev_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        lat_q   <= lat_d;
        astb_q  <= astb_d;
        prev_q  <= TRG_N[i];
      end
    end

    assign OUT[i]  = (state_q == S_HIGH);
    assign DONE[i] = (state_q == S_END);
  end

endmodule
